edge_pipe_seq: RTL and testbench
================================

Name: edge_pipe_seq

Overview:
- Frame-level sequencer for the edge-detector datapath. Runs a fixed chain of pixel-sweep stages (e.g. smoothing, intensity gradient, threshold) one after another over a shared pool of frame buffers.
- Each stage has a run/done interface: run held high advances one pixel per cycle, and done is high on the last pixel.
- The block clears each stage, holds its run, detects done, and routes distinct source and destination frame buffers to it.
- It reports frame completion or a watchdog error to the host.

Parameters:
- NUM_STG, 3, number of chained stages (>=1)
- NUM_FB, 3, number of frame buffers in the pool (>=2)
- FB_SEL_BITS, 2, width of buffer select (>= clog2(NUM_FB))
- STG_BITS, 2, width of stage index (>= clog2(NUM_STG))
- PIX_CNT, 4096, pixels per frame (IMG_WD*IMG_HT)
- WDOG_SLACK, 16, extra cycles allowed per stage beyond PIX_CNT before error
- CNT_BITS, 13, watchdog counter width (>= clog2(PIX_CNT+WDOG_SLACK+1))

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin a frame when idle
- abort  in  1  pulse; terminate current frame
- busy  out  1  high from accepted start until DONE/ERR exit
- frame_done  out  1  one-cycle pulse after last stage completes
- err  out  1  sticky watchdog/abort flag; cleared by next accepted start
- stg_clr_n  out  NUM_STG  per-stage synchronous clear, active-low, one-hot-low
- stg_run  out  NUM_STG  per-stage run, one-hot or zero
- stg_done  in  NUM_STG  per-stage done (combinational from stage)
- cur_stg  out  STG_BITS  index of active stage
- src_sel  out  FB_SEL_BITS  frame buffer read by active stage
- dst_sel  out  FB_SEL_BITS  frame buffer written by active stage

Behaviour:
- Reset values: state IDLE, busy=0, frame_done=0, err=0, stg_run=0, stg_clr_n=all 1, cur_stg=0, src_sel=0, dst_sel=1, watchdog=0. All outputs are registered or decoded from registered state only (Moore); there is no combinational path from stg_done to stg_run.
- Buffer routing:
  - src_sel = (base + cur_stg) mod NUM_FB; dst_sel = (base + cur_stg + 1) mod NUM_FB.
  - base = 0 at reset; base advances by NUM_STG mod NUM_FB after each frame_done, so the next frame's source is the previous frame's final output buffer.
  - src_sel != dst_sel always.
- States:
  - IDLE: start=1 -> CLEAR with cur_stg=0, err<=0, busy<=1. start while busy is ignored.
  - CLEAR: stg_clr_n[cur_stg]=0 for exactly one cycle; watchdog<=0 -> RUN.
  - RUN: stg_run[cur_stg]=1; watchdog increments each cycle.
    - If stg_done[cur_stg]=1 in a RUN cycle, run stays high that cycle so the last pixel is written, then -> NEXT.
    - If the watchdog reaches PIX_CNT+WDOG_SLACK without done -> ERR.
  - NEXT: stg_run=0 for one cycle (bubble). If cur_stg==NUM_STG-1 -> DONE; else cur_stg+1 -> CLEAR.
  - DONE: frame_done=1 for one cycle; base advances; busy<=0 -> IDLE.
  - ERR: err<=1, stg_run=0, busy<=0 -> IDLE. base is unchanged.
- stg_done of non-active stages is ignored.
- abort in CLEAR/RUN/NEXT -> ERR next cycle; this takes priority over done and watchdog in the same cycle. abort in IDLE/DONE is ignored.
- start and abort asserted together in IDLE: start wins.
- Nominal latency from start to frame_done: NUM_STG*(PIX_CNT+2)+2 cycles. Per stage this is 1 clear + PIX_CNT run + 1 bubble. (3 stages, 4096 px: 12296.)
- Reset mid-frame: returns immediately to reset values; stages are not cleared until the next CLEAR.
- Counters wrap nowhere; the watchdog saturates by leaving RUN.

Decomposition:
- Package edge_pipe_pkg: state enum (IDLE, CLEAR, RUN, NEXT, DONE, ERR) and a helper function for mod-NUM_FB buffer rotation.
- One natural sub-module: edge_pipe_wdog (load/increment/compare watchdog counter with expiry output). The FSM and routing stay in the top level.

Test Plan:
- Nominal frame: PIX_CNT=16, NUM_STG=3, stage models raise done on the 16th run cycle.
  - frame_done pulses 56 cycles after start.
  - (src,dst) per stage = (0,1),(1,2),(2,0); each stage sees exactly 16 run cycles with run high on the done cycle.
- Back-to-back frames: second start after frame_done -> stage 0 src_sel=0 (base advanced by 3 mod 3 = 0). With NUM_FB=2, base 0 -> 1 and stage 0 gets (1,0).
- Watchdog: stage 1 never asserts done, WDOG_SLACK=4 -> err=1 after 20 run cycles, stg_run=0, busy=0, no frame_done, base unchanged.
- Abort in RUN of stage 2, same cycle as stg_done -> ERR wins, err=1, no frame_done. Next start clears err.
- Ignored inputs:
  - start pulsed during RUN -> no effect.
  - stg_done of an inactive stage asserted -> no state change.
  - start+abort together in IDLE -> frame begins.
- Async reset asserted mid-RUN -> all outputs at reset values within the same cycle; a subsequent start runs a clean frame with the nominal latency.

Source files
------------

// File: rtl/edge_pipe_pkg.sv
// Shared types and helpers for the edge-detector frame sequencer.
// Covers the FSM state encoding and frame-buffer rotation arithmetic.
package edge_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    NEXT,
    DONE,
    ERR
  } state_t;

  // Buffer index reached by stepping 'step' places around a pool of num_fb buffers.
  function automatic int fb_rot(input int base, input int step, input int num_fb);
    return (base + step) % num_fb;
  endfunction

endpackage

// File: rtl/edge_pipe_wdog.sv
// Per-stage watchdog: cleared by load, counts run cycles on inc.
// expire flags the cycle whose increment reaches LIMIT.
module edge_pipe_wdog #(
  parameter int CNT_BITS = 13,
  parameter int LIMIT    = 4112
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic expire
);

  logic [CNT_BITS-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_BITS'(1);
    end
  end

  // Depends on the count only, so the FSM can use it without a combinational loop.
  assign expire = (count_reg == CNT_BITS'(LIMIT - 1));

endmodule

// File: rtl/edge_pipe_seq.sv
// Frame-level sequencer: clears, runs and retires each pixel-sweep stage in turn,
// routing rotating source/destination frame buffers and reporting done or error.
module edge_pipe_seq
  import edge_pipe_pkg::*;
#(
  parameter int NUM_STG     = 3,
  parameter int NUM_FB      = 3,
  parameter int FB_SEL_BITS = 2,
  parameter int STG_BITS    = 2,
  parameter int PIX_CNT     = 4096,
  parameter int WDOG_SLACK  = 16,
  parameter int CNT_BITS    = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic [NUM_STG-1:0]     stg_clr_n,
  output logic [NUM_STG-1:0]     stg_run,
  input  logic [NUM_STG-1:0]     stg_done,
  output logic [STG_BITS-1:0]    cur_stg,
  output logic [FB_SEL_BITS-1:0] src_sel,
  output logic [FB_SEL_BITS-1:0] dst_sel
);

  state_t                 state_reg, state_next;
  logic [STG_BITS-1:0]    cur_reg, cur_next;
  logic [FB_SEL_BITS-1:0] base_reg, base_next;
  logic                   busy_reg, busy_next;
  logic                   err_reg, err_next;
  logic                   wd_load, wd_inc, wd_expire;
  logic [NUM_STG-1:0]     sel;
  logic                   cur_done;
  logic                   last_stg;

  edge_pipe_wdog #(
    .CNT_BITS(CNT_BITS),
    .LIMIT   (PIX_CNT + WDOG_SLACK)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wd_load),
    .inc   (wd_inc),
    .expire(wd_expire)
  );

  // Stage controls are decoded from registered state only.
  for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_stg
    assign sel[gi]       = (cur_reg == STG_BITS'(gi));
    assign stg_run[gi]   = (state_reg == RUN) && sel[gi];
    assign stg_clr_n[gi] = !((state_reg == CLEAR) && sel[gi]);
  end

  assign cur_done = |(stg_done & sel);
  assign last_stg = (cur_reg == STG_BITS'(NUM_STG - 1));

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    base_next  = base_reg;
    busy_next  = busy_reg;
    err_next   = err_reg;
    wd_load    = 1'b0;
    wd_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          cur_next   = '0;
          err_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      CLEAR: begin
        wd_load    = 1'b1;
        state_next = abort ? ERR : RUN;
      end
      RUN: begin
        wd_inc = 1'b1;
        if (abort) begin
          state_next = ERR;
        end else if (cur_done) begin
          state_next = NEXT;
        end else if (wd_expire) begin
          state_next = ERR;
        end
      end
      NEXT: begin
        if (abort) begin
          state_next = ERR;
        end else if (last_stg) begin
          state_next = DONE;
        end else begin
          cur_next   = cur_reg + STG_BITS'(1);
          state_next = CLEAR;
        end
      end
      DONE: begin
        // Next frame reads from this frame's final output buffer.
        base_next  = FB_SEL_BITS'(fb_rot(int'(base_reg), NUM_STG, NUM_FB));
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      ERR: begin
        err_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      base_reg  <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      base_reg  <= base_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  assign busy       = busy_reg;
  assign err        = err_reg;
  assign frame_done = (state_reg == DONE);
  assign cur_stg    = cur_reg;
  assign src_sel    = FB_SEL_BITS'(fb_rot(int'(base_reg), int'(cur_reg), NUM_FB));
  assign dst_sel    = FB_SEL_BITS'(fb_rot(int'(base_reg), int'(cur_reg) + 1, NUM_FB));

endmodule

// File: tb/tb_edge_pipe_seq.sv
// Directed bench for edge_pipe_seq: two instances (3 and 2 frame buffers) driven
// by shared stimulus, each with behavioural 16-pixel stage models.
module tb_edge_pipe_seq;

  localparam int NS   = 3;
  localparam int PIX  = 16;
  localparam int SLCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stats_clr = 1'b0;
  logic [NS-1:0] hang = '0;
  logic [NS-1:0] xdone = '0;

  logic busy1, fd1, err1, busy2, fd2, err2;
  logic [NS-1:0] clr1, run1, done1, clr2, run2, done2;
  logic [1:0] cur1, src1, dst1, cur2, src2, dst2;

  int pc1[NS], pc2[NS], runs1[NS];
  int srcs1[NS], dsts1[NS], srcs2[NS], dsts2[NS];
  int checks = 0;
  int errors = 0;
  int fd, ed, e2;

  always #5 clk = ~clk;

  edge_pipe_seq #(.NUM_STG(NS), .NUM_FB(3), .FB_SEL_BITS(2), .STG_BITS(2),
                  .PIX_CNT(PIX), .WDOG_SLACK(SLCK), .CNT_BITS(13)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy1),
    .frame_done(fd1), .err(err1), .stg_clr_n(clr1), .stg_run(run1),
    .stg_done(done1), .cur_stg(cur1), .src_sel(src1), .dst_sel(dst1));

  edge_pipe_seq #(.NUM_STG(NS), .NUM_FB(2), .FB_SEL_BITS(2), .STG_BITS(2),
                  .PIX_CNT(PIX), .WDOG_SLACK(SLCK), .CNT_BITS(13)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy2),
    .frame_done(fd2), .err(err2), .stg_clr_n(clr2), .stg_run(run2),
    .stg_done(done2), .cur_stg(cur2), .src_sel(src2), .dst_sel(dst2));

  // Stage models: pixel counter cleared by clr_n, done on the 16th run cycle.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (!clr1[s]) pc1[s] <= 0; else if (run1[s]) pc1[s] <= pc1[s] + 1;
      if (!clr2[s]) pc2[s] <= 0; else if (run2[s]) pc2[s] <= pc2[s] + 1;
      if (stats_clr) begin
        runs1[s] <= 0;
        srcs1[s] <= -1; dsts1[s] <= -1; srcs2[s] <= -1; dsts2[s] <= -1;
      end else begin
        if (run1[s]) begin
          runs1[s] <= runs1[s] + 1;
          srcs1[s] <= int'(src1); dsts1[s] <= int'(dst1);
        end
        if (run2[s]) begin
          srcs2[s] <= int'(src2); dsts2[s] <= int'(dst2);
        end
      end
    end
  end

  always_comb begin
    done1 = xdone;
    done2 = xdone;
    for (int s = 0; s < NS; s++) begin
      if (run1[s] && pc1[s] == PIX - 1 && !hang[s]) done1[s] = 1'b1;
      if (run2[s] && pc2[s] == PIX - 1 && !hang[s]) done2[s] = 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Cycle 1 is the cycle start is high; inputs set in cycle n are sampled at its end.
  task automatic frame(input int abort_at, input int start_at, input int xd_at,
                       input logic [NS-1:0] xd_mask, input logic [NS-1:0] hmask,
                       output int fd_cyc, output int end_cyc, output int err_c2);
    int cyc;
    hang = hmask;
    start = 1'b1;
    abort = (abort_at == 1);
    stats_clr = 1'b1;
    fd_cyc = 0; end_cyc = 0; err_c2 = -1; cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      stats_clr = 1'b0;
      start = (cyc == start_at);
      abort = (cyc == abort_at);
      xdone = (cyc == xd_at) ? xd_mask : '0;
      if (fd1 && fd_cyc == 0) fd_cyc = cyc;
      if (cyc == 2) err_c2 = int'(err1);
      if (!busy1) begin
        end_cyc = cyc;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; xdone = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_run"}, int'(run1), 0);
    check({tag, "_clr_n"}, int'(clr1), 7);
    check({tag, "_fd"}, int'(fd1), 0);
    check({tag, "_cur"}, int'(cur1), 0);
    check({tag, "_src"}, int'(src1), 0);
    check({tag, "_dst"}, int'(dst1), 1);
    check({tag, "_src2"}, int'(src2), 0);
    check({tag, "_dst2"}, int'(dst2), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_err", int'(err1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A: nominal frame
    frame(0, 0, 0, '0, '0, fd, ed, e2);
    check("A_lat", fd, 56);
    check("A_end", ed, 57);
    check("A_err", int'(err1), 0);
    check("A_s0", srcs1[0] * 4 + dsts1[0], 0 * 4 + 1);
    check("A_s1", srcs1[1] * 4 + dsts1[1], 1 * 4 + 2);
    check("A_s2", srcs1[2] * 4 + dsts1[2], 2 * 4 + 0);
    for (int s = 0; s < NS; s++) check($sformatf("A_runs%0d", s), runs1[s], PIX);
    check("A2_s0", srcs2[0] * 4 + dsts2[0], 0 * 4 + 1);
    check("A2_s1", srcs2[1] * 4 + dsts2[1], 1 * 4 + 0);
    check("A2_s2", srcs2[2] * 4 + dsts2[2], 0 * 4 + 1);

    // B: back-to-back, start pulsed in RUN, inactive stages' done asserted
    frame(0, 10, 12, 3'b110, '0, fd, ed, e2);
    check("B_lat", fd, 56);
    check("B_end", ed, 57);
    check("B_s0", srcs1[0] * 4 + dsts1[0], 0 * 4 + 1);
    check("B_runs0", runs1[0], PIX);
    check("B2_s0", srcs2[0] * 4 + dsts2[0], 1 * 4 + 0);

    // C: stage 1 never finishes, watchdog trips after 20 run cycles
    frame(0, 0, 0, '0, 3'b010, fd, ed, e2);
    check("C_fd", fd, 0);
    check("C_end", ed, 42);
    check("C_runs1", runs1[1], PIX + SLCK);
    check("C_runs2", runs1[2], 0);
    check("C_err", int'(err1), 1);
    check("C_run", int'(run1), 0);
    repeat (2) @(negedge clk);
    check("C_err_sticky", int'(err1), 1);

    // D: abort coincides with stage 2 done
    frame(54, 0, 0, '0, '0, fd, ed, e2);
    check("D_err_clr", e2, 0);
    check("D2_s0", srcs2[0], 0);
    check("D_fd", fd, 0);
    check("D_end", ed, 56);
    check("D_err", int'(err1), 1);
    check("D_busy", int'(busy1), 0);

    // E: start and abort together in IDLE
    frame(1, 0, 0, '0, '0, fd, ed, e2);
    check("E_err_clr", e2, 0);
    check("E_lat", fd, 56);
    check("E_err", int'(err1), 0);
    check("E2_s0", srcs2[0] * 4 + dsts2[0], 0 * 4 + 1);

    // F: asynchronous reset mid-RUN of stage 1
    start = 1'b1;
    stats_clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stats_clr = 1'b0;
    repeat (28) @(negedge clk);
    check("F_pre_run", int'(run1), 2);
    #2 rst_n = 1'b0;
    #1 check_idle("F_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // G: clean frame after reset, base back at 0
    frame(0, 0, 0, '0, '0, fd, ed, e2);
    check("G_lat", fd, 56);
    check("G_runs0", runs1[0], PIX);
    check("G2_s0", srcs2[0] * 4 + dsts2[0], 0 * 4 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
